// File: rtl/pixel_result_buffer.sv
// Result FIFO between data_proc and the PicoRV32 bus: buffers processed pixels,
// tracks frame position, and exposes CTRL/STATUS/DATA/POS registers. Optional IRQ: PIXBUF_IRQ_EN.
module pixel_result_buffer #(
  parameter int DEPTH        = 16,
  parameter int FRAME_PIXELS = 1024,
  parameter int CNT_W        = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  pixel_in,
  input  logic        valid_in,
  output logic        ready_out,
  input  logic        mem_sel,
  input  logic [3:0]  mem_addr,
  input  logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        irq
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]       fifo_mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             enable, overflow, frame_done;
  logic [CNT_W-1:0] pix_idx, frame_cnt;
  logic [7:0]       ctrl_thresh;

  logic full, empty;
  logic bus_wr, ctrl_wr, stat_wr, clear, pop, push, drop, frame_wrap;
  logic ovf_w1c, fd_w1c;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  // Handshake: a pixel transfers on any cycle where valid_in && ready_out.
  // With enable=1 and the FIFO full, an offered pixel is dropped and overflow is set;
  // with enable=0 offered pixels are silently ignored.
  assign ready_out = enable && !full;
  assign push      = valid_in && ready_out;
  assign drop      = valid_in && enable && full;

  assign bus_wr  = mem_sel && (mem_wstrb != 4'h0);
  assign ctrl_wr = bus_wr && (mem_addr == 4'h0);
  assign stat_wr = bus_wr && (mem_addr == 4'h4);
  assign clear   = ctrl_wr && mem_wstrb[0] && mem_wdata[1];
  assign ovf_w1c = stat_wr && mem_wstrb[0] && mem_wdata[2];
  assign fd_w1c  = stat_wr && mem_wstrb[0] && mem_wdata[3];
  assign pop     = mem_sel && (mem_wstrb == 4'h0) && (mem_addr == 4'h8) && !empty;

  assign frame_wrap = push && (pix_idx == CNT_W'(FRAME_PIXELS - 1));

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= pixel_in;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      enable     <= 1'b0;
      overflow   <= 1'b0;
      frame_done <= 1'b0;
      pix_idx    <= '0;
      frame_cnt  <= '0;
    end else begin
      if (ctrl_wr && mem_wstrb[0]) enable <= mem_wdata[0];
      // Clear wins over any push/pop/flag activity in the same cycle.
      if (clear) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count      <= '0;
        overflow   <= 1'b0;
        frame_done <= 1'b0;
        pix_idx    <= '0;
        frame_cnt  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        if (push && !pop)      count <= count + (AW+1)'(1);
        else if (!push && pop) count <= count - (AW+1)'(1);

        if (frame_wrap) begin
          pix_idx   <= '0;
          frame_cnt <= frame_cnt + CNT_W'(1);
        end else if (push) begin
          pix_idx <= pix_idx + CNT_W'(1);
        end

        // A hardware set outranks a same-cycle write-1-to-clear.
        if (drop)         overflow <= 1'b1;
        else if (ovf_w1c) overflow <= 1'b0;
        if (frame_wrap)   frame_done <= 1'b1;
        else if (fd_w1c)  frame_done <= 1'b0;
      end
    end
  end

`ifdef PIXBUF_IRQ_EN
  logic [7:0] irq_thresh;
  logic       irq_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      irq_thresh <= 8'h00;
      irq_q      <= 1'b0;
    end else begin
      if (ctrl_wr && mem_wstrb[0]) irq_thresh[5:0] <= mem_wdata[7:2];
      if (ctrl_wr && mem_wstrb[1]) irq_thresh[7:6] <= mem_wdata[9:8];
      irq_q <= enable && (((9'(count) >= 9'(irq_thresh)) && (irq_thresh != 8'h00))
                          || overflow || frame_done);
    end
  end

  assign ctrl_thresh = irq_thresh;
  assign irq         = irq_q;
`else
  assign ctrl_thresh = 8'h00;
  assign irq         = 1'b0;
`endif

  logic unused_bus;
  assign unused_bus = ^{mem_wdata, mem_wstrb};

  // POS packs the index low and the frame count from bit 16 (CNT_W <= 16 expected).
  logic [31:0] pos_word;
  assign pos_word = 32'(pix_idx) | (32'(frame_cnt) << 16);

  always_comb begin
    mem_rdata = 32'h0;
    case (mem_addr)
      4'h0: mem_rdata = {22'h0, ctrl_thresh, 1'b0, enable};
      4'h4: mem_rdata = {15'h0, 9'(count), 4'h0, frame_done, overflow, full, empty};
      4'h8: mem_rdata = {23'h0, !empty, (empty ? 8'h00 : fifo_mem[rd_ptr])};
      4'hC: mem_rdata = pos_word;
      default: mem_rdata = 32'h0;
    endcase
  end

endmodule

// File: doc/pixel_result_buffer.md
Name: pixel_result_buffer

Overview:
Downstream stage of the data_proc pixel processor inside the image engine SoC top. Captures processed pixels (pixel_out/valid_out) into a synchronous FIFO, applies backpressure through ready_out, and tracks frame position. Exposes a small memory-mapped register window so the PicoRV32 drains pixels without loss instead of sampling a live output.

Parameters:
DEPTH, 16, FIFO entries; power of two, 2..256
FRAME_PIXELS, 1024, accepted pixels per frame; pixel index wraps here
CNT_W, 16, width of pixel-index and frame counters

Ports:
clk  input  1  system clock; all logic in this domain
rstn  input  1  asynchronous active-low reset
pixel_in  input  8  processed pixel from data_proc
valid_in  input  1  pixel_in valid
ready_out  output  1  buffer can accept; drives data_proc ready_in
mem_sel  input  1  bus select for this block, one-cycle pulse per access
mem_addr  input  4  register byte offset (mem_addr[3:0])
mem_wstrb  input  4  byte write strobes; 0 = read access
mem_wdata  input  32  write data
mem_rdata  output  32  read data, combinational from current state
irq  output  1  level interrupt (see Optional Feature)

Behaviour:
- Reset (async on rstn low, released sync to clk): FIFO empty, count 0, enable 0, overflow 0, frame_done 0, pixel index 0, frame count 0; ready_out 0, irq 0, mem_rdata reflects reset state.
- ready_out = enable && !full (combinational).
- Push: valid_in && ready_out -> pixel written at tail, count +1 next cycle. Single-cycle write latency; pixel is poppable the cycle after push.
- Drop: valid_in && enable && full -> pixel discarded, overflow set (sticky). valid_in while enable=0 -> ignored, no flag.
- Pop: mem_sel && mem_wstrb==0 && mem_addr==0x8 && !empty -> head returned on mem_rdata in that cycle, head advances at clock edge. Pop on empty -> returns valid bit 0, no state change.
- Simultaneous push+pop (non-empty, non-full): both occur, count unchanged. When full, ready_out is 0, so a pop in the same cycle does not admit the incoming pixel, which is dropped.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- Pixel index increments on each accepted push. At FRAME_PIXELS-1 it wraps to 0, sets frame_done (sticky), and increments frame count. The frame count wraps at 2^CNT_W.
- Clear (CTRL bit1 write): flushes FIFO, zeroes index and frame count, and clears overflow and frame_done. Self-clearing; reads back 0. Has priority over push/pop in the same cycle.
- Register map (word offsets; writes honour byte strobes):
  0x0 CTRL  RW: [0] enable, [1] clear (W1, self-clear), [9:2] irq_thresh (optional)
  0x4 STATUS R: [0] empty, [1] full, [2] overflow, [3] frame_done, [16:8] count; write 1 to [2]/[3] clears that flag
  0x8 DATA  R: [7:0] head pixel, [8] valid (=!empty); read pops
  0xC POS   R: [CNT_W-1:0] pixel index, [31:16] frame count
  Unmapped offsets read 0; writes ignored.
- A flag set and a W1C on the same cycle: the set wins.

Optional Feature:
PIXBUF_IRQ_EN: when defined, CTRL[9:2] holds irq_thresh (reset 0). irq = enable && (count >= irq_thresh && irq_thresh != 0 || overflow || frame_done), registered, so it asserts one cycle after the condition. When undefined, CTRL[9:2] reads 0 and ignores writes, and irq is tied 0.

Test Plan:
- Reset, then read STATUS -> 0x00000001 (empty). ready_out=0. Write CTRL=0x1 -> ready_out=1 next cycle.
- Push 0x11,0x22,0x33. Read DATA three times -> 0x111, 0x122, 0x133. Fourth read -> 0x000, count stays 0.
- Push 17 pixels with DEPTH=16 and no pops -> full=1, ready_out=0, overflow=1. Write STATUS 0x4 -> overflow=0, full stays 1.
- Push 1024 pixels with concurrent drains -> POS = 0x00010000, frame_done=1, no overflow.
- With FIFO at 5 entries, issue push and pop in the same cycle -> count stays 5. Write CTRL=0x3 -> count 0, POS 0, enable remains 1.
- With PIXBUF_IRQ_EN, set thresh=4 and push 4 pixels -> irq=1 one cycle after the 4th push; one pop -> irq=0 a cycle later.
